// File: rtl/layer_sequencer.sv
// Runs one inference as NUM_PASSES neuron passes and keeps a running signed argmax.
// Define SEQ_TIMEOUT_EN to add a watchdog that aborts a run when neuron_ready never arrives.
module layer_sequencer #(
  parameter int NUM_PASSES = 10,
  parameter int W          = 16,
  parameter int TIMEOUT    = 64,
  parameter int IW         = $clog2(NUM_PASSES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic          neuron_ready,
  input  logic [W-1:0]  score_in,
  output logic          neuron_start,
  output logic [IW-1:0] pass_idx,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] best_idx,
  output logic [W-1:0]  best_val,
  output logic          error
);

  // state | meaning
  // IDLE  | waiting for go; results from the last run held
  // START | one-cycle neuron_start pulse for pass_idx
  // WAIT  | waiting for neuron_ready, then capture the score
  // NEXT  | advance to the next pass or finish
  // DONE  | one-cycle done pulse
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] NEXT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [IW-1:0] LAST_PASS = IW'(NUM_PASSES - 1);

  if (NUM_PASSES < 2 || TIMEOUT < 2) begin : g_bad_cfg
    $error("layer_sequencer: NUM_PASSES and TIMEOUT must both be at least 2");
  end

  logic [2:0] state;
  logic       timeout_hit;
  logic       take_score;

  assign neuron_start = (state == START);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  // Pass 0 seeds the argmax; later passes need a strictly larger score so ties keep the lower index.
  assign take_score = (pass_idx == '0) || ($signed(score_in) > $signed(best_val));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pass_idx <= '0;
      best_idx <= '0;
      best_val <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state    <= START;
            pass_idx <= '0;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (neuron_ready) begin
            state <= NEXT;
            if (take_score) begin
              best_val <= score_in;
              best_idx <= pass_idx;
            end
          end else if (timeout_hit) begin
            state <= DONE;
          end
        end
        NEXT: begin
          if (pass_idx == LAST_PASS) begin
            state <= DONE;
          end else begin
            pass_idx <= pass_idx + IW'(1);
            state    <= START;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] wdog;

  // Loaded in START so it is fresh on every WAIT entry; expiry lands on the TIMEOUT-th WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= '0;
    end else if (state == START) begin
      wdog <= TW'(TIMEOUT - 1);
    end else if (state == WAIT && wdog != '0) begin
      wdog <= wdog - TW'(1);
    end
  end

  assign timeout_hit = (state == WAIT) && !neuron_ready && (wdog == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error <= 1'b0;
    end else if (state == IDLE && go) begin
      error <= 1'b0;
    end else if (timeout_hit) begin
      error <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: expected start indices and run results are queued
// when a run is launched and popped when the DUT pulses neuron_start or done.
module tb_layer_sequencer;
  localparam int N  = 10;
  localparam int W  = 16;
  localparam int TO = 64;
  localparam int IW = 4;
  localparam int L  = 35;

  typedef struct {
    int idx;
    int val;
    int rel;
    int err;
    int pidx;
  } result_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          neuron_ready = 1'b0;
  logic [W-1:0]  score_in = '0;
  logic          neuron_start;
  logic [IW-1:0] pass_idx;
  logic          busy;
  logic          done;
  logic [IW-1:0] best_idx;
  logic [W-1:0]  best_val;
  logic          error;

  layer_sequencer #(.NUM_PASSES(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .neuron_ready(neuron_ready), .score_in(score_in),
    .neuron_start(neuron_start), .pass_idx(pass_idx), .busy(busy), .done(done),
    .best_idx(best_idx), .best_val(best_val), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int go_cyc = 0;
  int resp_n = 0;
  int silent_at = -1;
  bit spur = 1'b0;
  bit prev_start = 1'b0;
  int cur_scores [N];
  int start_q [$];
  result_t result_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Neuron controller model: ready arrives L cycles after the start cycle.
  task automatic respond(input int sc);
    if (spur) begin neuron_ready = 1'b1; score_in = 16'(32767); end
    @(posedge clk); #1 neuron_ready = 1'b0;
    repeat (L - 1) @(posedge clk);
    #1 neuron_ready = 1'b1; score_in = 16'(sc);
    @(posedge clk); #1;
    if (spur) begin
      score_in = 16'(32767);
      @(posedge clk); #1;
    end
    neuron_ready = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (neuron_start && rst_n) begin
        int p;
        p = resp_n;
        resp_n++;
        if (p != silent_at && p < N) respond(cur_scores[p]);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT produces a start or done.
  initial begin
    forever begin
      @(negedge clk);
      if (neuron_start) begin
        check("start_one_cycle", prev_start, 0);
        if (start_q.size() == 0) check("unexpected_start", 1, 0);
        else check("start_pass_idx", pass_idx, start_q.pop_front());
      end
      prev_start = neuron_start;
      if (done) begin
        if (result_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          result_t r;
          r = result_q.pop_front();
          check("best_idx", best_idx, r.idx);
          check("best_val", $signed(best_val), r.val);
          check("done_cycle", cyc - go_cyc, r.rel);
          check("error_at_done", error, r.err);
          check("pass_idx_at_done", pass_idx, r.pidx);
          check("starts_consumed", start_q.size(), 0);
        end
      end
    end
  end

  // Queue expectations for a run over the first npass passes, then raise go.
  task automatic start_run(input bit hold, input int npass, input int rel, input int err);
    result_t r;
    r.idx = 0;
    r.val = cur_scores[0];
    for (int i = 1; i < npass; i++)
      if (cur_scores[i] > r.val) begin r.val = cur_scores[i]; r.idx = i; end
    r.rel  = rel;
    r.err  = err;
    r.pidx = npass - 1;
    for (int i = 0; i < npass; i++) start_q.push_back(i);
    result_q.push_back(r);
    resp_n = 0;
    @(negedge clk);
    go = 1'b1;
    go_cyc = cyc;
    if (!hold) begin @(negedge clk); go = 1'b0; end
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (result_q.size() != 0 && n < limit) begin @(negedge clk); n++; end
    if (result_q.size() != 0) begin
      check(tag, 0, 1);
      result_q.delete();
      start_q.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_start"}, neuron_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass_idx"}, pass_idx, 0);
    check({tag, "_best_idx"}, best_idx, 0);
    check({tag, "_best_val"}, best_val, 0);
    check({tag, "_error"}, error, 0);
  endtask

  localparam int FULL_REL = N * (L + 2) + 1;  // go cycle through done cycle spans N*(L+2)+2 cycles

  initial begin
    int bad;
    int n;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Mixed scores with a tie at pass 3 that must not displace pass 2.
    cur_scores = '{5, -3, 7, 7, 2, 0, 1, -8, 6, 4};
    start_run(1'b0, N, FULL_REL, 0);
    wait_done("run1_timeout", 1000);
    @(negedge clk);
    check("run1_idle_busy", busy, 0);
    check("run1_hold_idx", best_idx, 2);

    // All negative: exercises the signed compare and the unconditional pass-0 load.
    for (int i = 0; i < N; i++) cur_scores[i] = -100 + i;
    start_run(1'b0, N, FULL_REL, 0);
    wait_done("run2_timeout", 1000);

    // go held throughout, spurious ready in START and NEXT.
    cur_scores = '{3, 12, -7, 12, 40, 1, 39, 0, -40, 2};
    spur = 1'b1;
    start_run(1'b1, N, N * (L + 2) + 1, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 1000);
    go = 1'b0;
    if (!done) check("run3_timeout", 0, 1);
    spur = 1'b0;
    repeat (5) @(negedge clk);
    check("run3_single_run_busy", busy, 0);
    check("run3_no_extra_starts", start_q.size(), 0);
    result_q.delete();
    start_q.delete();

    // Asynchronous reset in WAIT of pass 4, then a clean restart.
    cur_scores = '{5, -3, 7, 7, 2, 0, 1, -8, 6, 4};
    start_run(1'b0, N, FULL_REL, 0);
    n = 0;
    while (resp_n < 5 && n < 1000) begin @(negedge clk); n++; end
    check("rst_reached_pass4", resp_n, 5);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    result_q.delete();
    start_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    start_run(1'b0, N, FULL_REL, 0);
    wait_done("restart_timeout", 1000);

`ifdef SEQ_TIMEOUT_EN
    // Silent responder at pass 3: watchdog aborts, results from passes 0-2 freeze.
    cur_scores = '{1, 9, 4, 20, 30, 0, 0, 0, 0, 0};
    silent_at = 3;
    start_run(1'b0, 4, 3 * (L + 2) + 2 + TO, 1);
    wait_done("wdog_timeout", 1000);
    @(negedge clk);
    check("wdog_error_held", error, 1);
    start_q.push_back(0);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("wdog_error_cleared", error, 0);
    rst_n = 1'b0;
    #1 start_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    silent_at = -1;
`else
    // Silent responder without a watchdog: the run never finishes.
    silent_at = 0;
    start_q.push_back(0);
    resp_n = 0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy || done) bad++;
    end
    check("silent_never_done", bad, 0);
    check("silent_error", error, 0);
    rst_n = 1'b0;
    #1 start_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    silent_at = -1;
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
